// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter placing one outstanding transaction at a time onto a
// single-port memory wrapper, with a timeout abort for a missing ack.
module mem_req_arbiter #(
    parameter int N_PORTS = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_PORTS-1:0]    port_req,
    input  logic [N_PORTS-1:0]    port_we,
    input  logic [64*N_PORTS-1:0] port_addr,
    input  logic [64*N_PORTS-1:0] port_wdata,
    output logic [N_PORTS-1:0]    port_ack,
    output logic [N_PORTS-1:0]    port_err,
    output logic [63:0]           port_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [63:0]           mem_addr,
    output logic [63:0]           mem_wdata,
    input  logic [63:0]           mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy
);

    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant;
    logic [CW-1:0] cnt;

    logic          win_valid;
    logic [GW-1:0] win_idx;

    // Scan from the port after the last winner, wrapping, and take the first requester.
    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        int idx;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(last_grant) + k) % N_PORTS;
            if (!win_valid && port_req[idx]) begin
                win_valid = 1'b1;
                win_idx   = GW'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= GW'(N_PORTS - 1);
            grant      <= '0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            port_ack   <= '0;
            port_err   <= '0;
            port_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        grant      <= win_idx;
                        last_grant <= win_idx;
                        mem_req    <= 1'b1;
                        mem_we     <= port_we[win_idx];
                        mem_addr   <= port_addr[64*int'(win_idx) +: 64];
                        mem_wdata  <= port_wdata[64*int'(win_idx) +: 64];
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_req <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        if (!mem_we) begin
                            port_rdata <= mem_rdata;
                        end
                        port_ack[grant] <= 1'b1;
                        state           <= S_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        port_err[grant] <= 1'b1;
                        state           <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // No arbitration here: a requester dropping req in its ack cycle is not re-granted.
                    port_ack <= '0;
                    port_err <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: vector table of single transactions plus
// hand-written contention, timeout, reset-mid-wait and spurious-valid sequences.
module tb_mem_req_arbiter;

    localparam int N_PORTS = 2;
    localparam int TIMEOUT = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_PORTS-1:0]    port_req;
    logic [N_PORTS-1:0]    port_we;
    logic [64*N_PORTS-1:0] port_addr;
    logic [64*N_PORTS-1:0] port_wdata;
    logic [N_PORTS-1:0]    port_ack;
    logic [N_PORTS-1:0]    port_err;
    logic [63:0]           port_rdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [63:0]           mem_addr;
    logic [63:0]           mem_wdata;
    logic [63:0]           mem_rdata;
    logic                  mem_valid;
    logic                  busy;

    mem_req_arbiter #(.N_PORTS(N_PORTS), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_req   (port_req),
        .port_we    (port_we),
        .port_addr  (port_addr),
        .port_wdata (port_wdata),
        .port_ack   (port_ack),
        .port_err   (port_err),
        .port_rdata (port_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One-cycle memory model; inj_* lets the bench force spurious or late acks.
    bit  [63:0] mem_arr [64];
    logic       mem_ok;
    logic       model_valid = 1'b0;
    logic [63:0] model_rdata = '0;
    logic       inj_valid;
    logic [63:0] inj_rdata;

    always @(posedge clk) begin
        model_valid <= mem_req && mem_ok;
        if (mem_req) begin
            model_rdata <= mem_arr[mem_addr[8:3]];
            if (mem_we) mem_arr[mem_addr[8:3]] <= mem_wdata;
        end
    end

    assign mem_valid = model_valid | inj_valid;
    assign mem_rdata = inj_valid ? inj_rdata : model_rdata;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input int p, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        port_we[p]              = we;
        port_addr[64*p +: 64]   = addr;
        port_wdata[64*p +: 64]  = wdata;
    endtask

    // Single transaction on an otherwise idle arbiter with a responsive memory.
    task automatic do_txn(input int p, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rd, input string tag);
        int lat;
        bit done;
        logic [63:0] onehot;
        onehot = 64'd1 << p;
        @(negedge clk);
        set_cmd(p, we, addr, wdata);
        port_req[p] = 1'b1;
        @(negedge clk);
        check({tag, ".mem_req"}, {63'd0, mem_req}, 64'd1);
        check({tag, ".mem_addr"}, mem_addr, addr);
        check({tag, ".mem_we"}, {63'd0, mem_we}, {63'd0, we});
        if (we) check({tag, ".mem_wdata"}, mem_wdata, wdata);
        check({tag, ".busy"}, {63'd0, busy}, 64'd1);
        lat  = 1;
        done = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) check({tag, ".mem_req_pulse"}, {63'd0, mem_req}, 64'd0);
            if (port_ack != '0 || port_err != '0) done = 1'b1;
        end
        check({tag, ".latency"}, 64'(lat), 64'd3);
        check({tag, ".ack"}, 64'(port_ack), onehot);
        check({tag, ".err"}, 64'(port_err), 64'd0);
        check({tag, ".rdata"}, port_rdata, exp_rd);
        port_req[p] = 1'b0;
        @(negedge clk);
        check({tag, ".ack_clear"}, 64'(port_ack), 64'd0);
        check({tag, ".idle"}, {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        int          port;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        int cyc;
        bit ack_seen;
        int acks [2];
        int order [$];
        logic [N_PORTS-1:0] prev_ack;

        vecs[0] = '{1, 1'b1, 64'h100, 64'hDEAD_BEEF,          64'h0};
        vecs[1] = '{0, 1'b0, 64'h100, 64'h0,                  64'hDEAD_BEEF};
        vecs[2] = '{1, 1'b1, 64'h8,   64'h55AA,               64'hDEAD_BEEF};
        vecs[3] = '{1, 1'b0, 64'h8,   64'h0,                  64'h55AA};
        vecs[4] = '{0, 1'b0, 64'h40,  64'h0,                  64'h0};
        vecs[5] = '{0, 1'b1, 64'h18,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[6] = '{1, 1'b0, 64'h18,  64'h0,                  64'hFFFF_FFFF_FFFF_FFFF};

        rst_n      = 1'b0;
        port_req   = '0;
        port_we    = '0;
        port_addr  = '0;
        port_wdata = '0;
        mem_ok     = 1'b1;
        inj_valid  = 1'b0;
        inj_rdata  = '0;

        repeat (3) @(negedge clk);
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.mem_req", {63'd0, mem_req}, 64'd0);
        check("reset.mem_addr", mem_addr, 64'd0);
        check("reset.ack", 64'(port_ack), 64'd0);
        check("reset.err", 64'(port_err), 64'd0);
        check("reset.rdata", port_rdata, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                   $sformatf("vec%0d", i));

        // Contention from a fresh reset: both ports read continuously for 3 transactions each.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_cmd(0, 1'b0, 64'h100, 64'h0);
        set_cmd(1, 1'b0, 64'h8, 64'h0);
        port_req = 2'b11;
        acks[0]  = 0;
        acks[1]  = 0;
        prev_ack = '0;
        cyc      = 0;
        while ((acks[0] < 3 || acks[1] < 3) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (port_ack != '0) begin
                check("cont.ack_spacing", 64'(prev_ack), 64'd0);
                check("cont.ack_onehot", 64'($countones(port_ack)), 64'd1);
                if (port_ack[1]) begin
                    order.push_back(1);
                    acks[1]++;
                    check("cont.rdata1", port_rdata, 64'h55AA);
                    if (acks[1] == 3) port_req[1] = 1'b0;
                end else begin
                    order.push_back(0);
                    acks[0]++;
                    check("cont.rdata0", port_rdata, 64'hDEAD_BEEF);
                    if (acks[0] == 3) port_req[0] = 1'b0;
                end
            end
            prev_ack = port_ack;
        end
        check("cont.acks0", 64'(acks[0]), 64'd3);
        check("cont.acks1", 64'(acks[1]), 64'd3);
        check("cont.order_len", 64'(order.size()), 64'd6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            check($sformatf("cont.order%0d", i), 64'(order[i]), 64'(i % 2));

        // Timeout: memory silent; err must land 8 cycles after WAIT entry (10 after request).
        @(negedge clk);
        mem_ok = 1'b0;
        set_cmd(0, 1'b0, 64'h40, 64'h0);
        port_req[0] = 1'b1;
        lat      = 0;
        ack_seen = 1'b0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (port_ack != '0) ack_seen = 1'b1;
            if (port_err != '0) break;
        end
        check("tmo.latency", 64'(lat), 64'd10);
        check("tmo.err", 64'(port_err), 64'd1);
        check("tmo.no_ack", {63'd0, ack_seen}, 64'd0);
        check("tmo.rdata", port_rdata, 64'h55AA);
        port_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        inj_valid = 1'b1;
        inj_rdata = 64'h77;
        @(negedge clk);
        inj_valid = 1'b0;
        check("late.ack", 64'(port_ack), 64'd0);
        check("late.rdata", port_rdata, 64'h55AA);
        check("late.busy", {63'd0, busy}, 64'd0);
        mem_ok = 1'b1;
        do_txn(0, 1'b0, 64'h100, 64'h0, 64'hDEAD_BEEF, "post_tmo");

        // Reset mid-WAIT with port 1 last granted.
        do_txn(1, 1'b0, 64'h8, 64'h0, 64'h55AA, "pre_rst");
        @(negedge clk);
        mem_ok = 1'b0;
        set_cmd(1, 1'b0, 64'h100, 64'h0);
        port_req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstw.in_wait", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        port_req = '0;
        check("rstw.busy", {63'd0, busy}, 64'd0);
        check("rstw.mem_req", {63'd0, mem_req}, 64'd0);
        check("rstw.mem_we", {63'd0, mem_we}, 64'd0);
        check("rstw.mem_addr", mem_addr, 64'd0);
        check("rstw.mem_wdata", mem_wdata, 64'd0);
        check("rstw.ack", 64'(port_ack), 64'd0);
        check("rstw.err", 64'(port_err), 64'd0);
        check("rstw.rdata", port_rdata, 64'd0);
        inj_valid = 1'b1;
        inj_rdata = 64'h99;
        @(negedge clk);
        inj_valid = 1'b0;
        check("rstw.late_ack", 64'(port_ack), 64'd0);
        check("rstw.late_err", 64'(port_err), 64'd0);
        check("rstw.late_rdata", port_rdata, 64'd0);
        mem_ok = 1'b1;
        set_cmd(0, 1'b0, 64'h100, 64'h0);
        set_cmd(1, 1'b0, 64'h8, 64'h0);
        port_req = 2'b11;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (port_ack != '0 || port_err != '0) break;
        end
        check("rstw.first_lat", 64'(lat), 64'd3);
        check("rstw.first_grant", 64'(port_ack), 64'd1);
        check("rstw.first_rdata", port_rdata, 64'hDEAD_BEEF);
        port_req[0] = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (port_ack != '0 || port_err != '0) break;
        end
        check("rstw.second_grant", 64'(port_ack), 64'd2);
        check("rstw.second_rdata", port_rdata, 64'h55AA);
        port_req[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Spurious mem_valid while idle.
        inj_valid = 1'b1;
        inj_rdata = 64'h1234;
        @(negedge clk);
        inj_valid = 1'b0;
        check("spur.ack", 64'(port_ack), 64'd0);
        check("spur.busy", {63'd0, busy}, 64'd0);
        check("spur.rdata", port_rdata, 64'h55AA);
        @(negedge clk);
        check("spur.ack2", 64'(port_ack), 64'd0);
        check("spur.rdata2", port_rdata, 64'h55AA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
